// File: rtl/sprite_pkg.sv
// Sprite line fetcher shared definitions.
//   - Sprite geometry (16x16 pixels, 2 bits per pixel, one 32-bit word per row).
//   - Bit positions of the fields in a sprite attribute word.
//   - Fetch FSM state encoding.
// Optional feature macro: SPRITE_HFLIP_EN (used by the modules importing this package).
package sprite_pkg;

    localparam int SPR_W = 16;
    localparam int SPR_H = 16;
    localparam int BPP   = 2;
    localparam int WORD_W = SPR_W * BPP;

    // Attribute word layout
    localparam int ATTR_EN    = 31;
    localparam int ATTR_HFLIP = 30;
    localparam int ATTR_ID_HI = 24;
    localparam int ATTR_ID_LO = 20;
    localparam int ATTR_Y_HI  = 19;
    localparam int ATTR_Y_LO  = 10;
    localparam int ATTR_X_HI  = 9;
    localparam int ATTR_X_LO  = 0;

    localparam int ID_W  = ATTR_ID_HI - ATTR_ID_LO + 1;
    localparam int ROW_W = $clog2(SPR_H);
    localparam int COL_W = $clog2(SPR_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sprite_slot_line.sv
// Per-slot double-buffered sprite line storage.
// Holds {valid, x, word} (plus hflip when SPRITE_HFLIP_EN is defined) for two
// banks: one written by the fetch engine, one read by the pixel path.
// Ports:
//   clk, reset            clock, synchronous active-high reset (clears valids)
//   clr_i / clr_bank_i    invalidate one bank (start of a new fetch)
//   wr_i / wr_bank_i      capture wr_x_i / wr_word_i (/ wr_hflip_i) into a bank
//   rd_bank_i             bank used by the pixel path
//   pix_x_i               current pixel x
//   pix_o                 colour of this slot at pix_x_i, 0 if none/transparent
// Optional feature macro: SPRITE_HFLIP_EN (mirror pixel index when hflip set).
module sprite_slot_line
    import sprite_pkg::*;
#(
    parameter int X_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              clr_bank_i,
    input  logic              wr_i,
    input  logic              wr_bank_i,
    input  logic [X_W-1:0]    wr_x_i,
    input  logic [WORD_W-1:0] wr_word_i,
`ifdef SPRITE_HFLIP_EN
    input  logic              wr_hflip_i,
`endif
    input  logic              rd_bank_i,
    input  logic [X_W-1:0]    pix_x_i,
    output logic [BPP-1:0]    pix_o
);

    logic [1:0]             valid_q;
    logic [1:0][X_W-1:0]    x_q;
    logic [1:0][WORD_W-1:0] word_q;
`ifdef SPRITE_HFLIP_EN
    logic [1:0]             hflip_q;
`endif

    // The top never clears and writes the same bank in one cycle; if it did,
    // the write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            if (clr_i) valid_q[clr_bank_i] <= 1'b0;
            if (wr_i)  valid_q[wr_bank_i]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_i) begin
            x_q[wr_bank_i]    <= wr_x_i;
            word_q[wr_bank_i] <= wr_word_i;
`ifdef SPRITE_HFLIP_EN
            hflip_q[wr_bank_i] <= wr_hflip_i;
`endif
        end
    end

    // Modular column: sprites near the right edge wrap onto the line start.
    logic [X_W-1:0]   col;
    logic             in_rng;
    logic [COL_W-1:0] pidx;

    assign col    = pix_x_i - x_q[rd_bank_i];
    assign in_rng = (col < X_W'(SPR_W));

`ifdef SPRITE_HFLIP_EN
    // 15 - col for a 4-bit column is its bitwise inverse.
    assign pidx = hflip_q[rd_bank_i] ? ~col[COL_W-1:0] : col[COL_W-1:0];
`else
    assign pidx = col[COL_W-1:0];
`endif

    assign pix_o = (valid_q[rd_bank_i] && in_rng)
                   ? word_q[rd_bank_i][int'(pidx) * BPP +: BPP] : '0;

endmodule

// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher: per scanline, scans NUM_SLOTS attribute slots, fetches
// the matching sprite row words through the sprite memory's registered read
// port into a double-buffered line store, and serves per-pixel 2bpp colour.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   attr_we/attr_slot/attr_wdata        attribute slot write
//   line_start, line_y                  start (or restart) fetch for a scanline
//   mem_raddr, mem_rdata                sprite memory read port (1-cycle latency)
//   fetch_busy                          fetch in progress
//   pix_valid, pix_x                    pixel strobe and x
//   pix_hit, pix_color, pix_slot        winning sprite pixel (registered)
// Optional feature macro: SPRITE_HFLIP_EN (attribute bit 30 mirrors the sprite).
module sprite_line_fetcher
    import sprite_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int X_W       = 10,
    parameter int Y_W       = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         attr_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] attr_slot,
    input  logic [31:0]                  attr_wdata,
    input  logic                         line_start,
    input  logic [Y_W-1:0]               line_y,
    output logic [8:0]                   mem_raddr,
    input  logic [31:0]                  mem_rdata,
    output logic                         fetch_busy,
    input  logic                         pix_valid,
    input  logic [X_W-1:0]               pix_x,
    output logic                         pix_hit,
    output logic [1:0]                   pix_color,
    output logic [$clog2(NUM_SLOTS)-1:0] pix_slot
);

    localparam int SW = $clog2(NUM_SLOTS);

    // ------------------------------------------------------------------
    // Attribute registers
    // ------------------------------------------------------------------
    logic [NUM_SLOTS-1:0]           en_q;
    logic [NUM_SLOTS-1:0][ID_W-1:0] id_q;
    logic [NUM_SLOTS-1:0][Y_W-1:0]  y_q;
    logic [NUM_SLOTS-1:0][X_W-1:0]  x_q;
`ifdef SPRITE_HFLIP_EN
    logic [NUM_SLOTS-1:0]           hf_q;
    logic                           unused_attr_bits;
    assign unused_attr_bits = ^attr_wdata[29:25];
`else
    logic                           unused_attr_bits;
    assign unused_attr_bits = ^attr_wdata[30:25];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q <= '0;
        end else if (attr_we) begin
            en_q[attr_slot] <= attr_wdata[ATTR_EN];
        end
    end

    always_ff @(posedge clk) begin
        if (attr_we) begin
            id_q[attr_slot] <= attr_wdata[ATTR_ID_HI:ATTR_ID_LO];
            y_q[attr_slot]  <= Y_W'(attr_wdata[ATTR_Y_HI:ATTR_Y_LO]);
            x_q[attr_slot]  <= X_W'(attr_wdata[ATTR_X_HI:ATTR_X_LO]);
`ifdef SPRITE_HFLIP_EN
            hf_q[attr_slot] <= attr_wdata[ATTR_HFLIP];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    fetch_state_e   state_q, state_d;
    logic [SW-1:0]  idx_q, idx_d;
    logic [Y_W-1:0] line_y_q, line_y_d;
    logic           front_q, front_d;     // bank index read by the pixel path
    // Issue-to-capture pipeline: hit flag plus what the capture needs.
    logic           hit_q, hit_d;
    logic [SW-1:0]  cap_slot_q, cap_slot_d;
    logic [X_W-1:0] cap_x_q, cap_x_d;
`ifdef SPRITE_HFLIP_EN
    logic           cap_hf_q, cap_hf_d;
`endif

    logic [Y_W-1:0] row_full;
    logic           row_hit;

    assign row_full = line_y_q - y_q[idx_q];
    assign row_hit  = en_q[idx_q] && (row_full < Y_W'(SPR_H));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        line_y_d   = line_y_q;
        front_d    = front_q;
        hit_d      = 1'b0;
        cap_slot_d = idx_q;
        cap_x_d    = x_q[idx_q];
`ifdef SPRITE_HFLIP_EN
        cap_hf_d   = hf_q[idx_q];
`endif
        mem_raddr  = '0;
        fetch_busy = (state_q != ST_IDLE);

        case (state_q)
            ST_FETCH: begin
                mem_raddr = {id_q[idx_q], row_full[ROW_W-1:0]};
                hit_d     = row_hit;
                if (idx_q == SW'(NUM_SLOTS - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  ;
        endcase

        // A new line (including an abort) swaps banks and restarts at slot 0.
        // The slot issued this cycle is dropped; the one being captured this
        // cycle still lands in the bank that is about to become front.
        if (line_start) begin
            state_d  = ST_FETCH;
            idx_d    = '0;
            line_y_d = line_y;
            front_d  = ~front_q;
            hit_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            line_y_q   <= '0;
            front_q    <= 1'b0;
            hit_q      <= 1'b0;
            cap_slot_q <= '0;
            cap_x_q    <= '0;
`ifdef SPRITE_HFLIP_EN
            cap_hf_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            line_y_q   <= line_y_d;
            front_q    <= front_d;
            hit_q      <= hit_d;
            cap_slot_q <= cap_slot_d;
            cap_x_q    <= cap_x_d;
`ifdef SPRITE_HFLIP_EN
            cap_hf_q   <= cap_hf_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Per-slot line storage
    // ------------------------------------------------------------------
    logic [NUM_SLOTS-1:0][BPP-1:0] slot_pix;

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        sprite_slot_line #(
            .X_W(X_W)
        ) u_line (
            .clk        (clk),
            .reset      (reset),
            .clr_i      (line_start),
            .clr_bank_i (front_q),
            .wr_i       (hit_q && (cap_slot_q == SW'(s))),
            .wr_bank_i  (~front_q),
            .wr_x_i     (cap_x_q),
            .wr_word_i  (mem_rdata),
`ifdef SPRITE_HFLIP_EN
            .wr_hflip_i (cap_hf_q),
`endif
            .rd_bank_i  (front_q),
            .pix_x_i    (pix_x),
            .pix_o      (slot_pix[s])
        );
    end

    // ------------------------------------------------------------------
    // Priority select: lowest-numbered non-transparent slot wins
    // ------------------------------------------------------------------
    logic          win_hit;
    logic [1:0]    win_color;
    logic [SW-1:0] win_slot;

    always_comb begin
        win_hit   = 1'b0;
        win_color = '0;
        win_slot  = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (slot_pix[s] != '0) begin
                win_hit   = 1'b1;
                win_color = slot_pix[s];
                win_slot  = SW'(s);
            end
        end
    end

    logic          pix_hit_q;
    logic [1:0]    pix_color_q;
    logic [SW-1:0] pix_slot_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_hit_q   <= 1'b0;
            pix_color_q <= '0;
            pix_slot_q  <= '0;
        end else begin
            pix_hit_q   <= pix_valid && win_hit;
            pix_color_q <= pix_valid ? win_color : 2'b00;
            if (pix_valid) pix_slot_q <= win_slot;
        end
    end

    assign pix_hit   = pix_hit_q;
    assign pix_color = pix_color_q;
    assign pix_slot  = pix_slot_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
module tb_sprite_line_fetcher;
    localparam int NS = 8;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          attr_we;
    logic [SW-1:0] attr_slot;
    logic [31:0]   attr_wdata;
    logic          line_start;
    logic [YW-1:0] line_y;
    logic [8:0]    mem_raddr;
    logic [31:0]   mem_rdata;
    logic          fetch_busy;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic          pix_hit;
    logic [1:0]    pix_color;
    logic [SW-1:0] pix_slot;

    sprite_line_fetcher #(.NUM_SLOTS(NS), .X_W(XW), .Y_W(YW)) dut (
        .clk(clk), .reset(reset), .attr_we(attr_we), .attr_slot(attr_slot),
        .attr_wdata(attr_wdata), .line_start(line_start), .line_y(line_y),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .fetch_busy(fetch_busy),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_hit(pix_hit),
        .pix_color(pix_color), .pix_slot(pix_slot)
    );

    always #5 clk = ~clk;

    // Sprite memory with a registered read port
    logic [31:0] mem [512];
    always @(posedge clk) mem_rdata <= mem[mem_raddr];

    // Reference model: attributes and the two line banks as plain arrays
    bit          m_en[NS], m_hf[NS];
    int          m_id[NS], m_y[NS], m_x[NS];
    bit          f_v[NS], b_v[NS], f_hf[NS], b_hf[NS];
    int          f_x[NS], b_x[NS];
    logic [31:0] f_w[NS], b_w[NS];

    int n_vec = 0;
    int n_err = 0;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int s = 0; s < NS; s++) begin
            m_en[s] = 0; f_v[s] = 0; b_v[s] = 0;
        end
    endtask

    task automatic wr_attr(int s, bit en, bit hf, int id, int y, int x);
        logic [4:0] id5;
        logic [9:0] y10, x10;
        id5 = id[4:0]; y10 = y[9:0]; x10 = x[9:0];
        attr_we = 1'b1; attr_slot = s[SW-1:0];
        attr_wdata = {en, hf, 5'b00000, id5, y10, x10};
        @(negedge clk);
        attr_we = 1'b0;
        m_en[s] = en; m_hf[s] = hf; m_id[s] = id & 31; m_y[s] = y & 1023; m_x[s] = x & 1023;
    endtask

    // prev_cnt: number of slots the previous fetch got to capture before this line_start
    task automatic start_line(int ly, int prev_cnt);
        int row;
        for (int s = prev_cnt; s < NS; s++) b_v[s] = 0;
        for (int s = 0; s < NS; s++) begin
            f_v[s] = b_v[s]; f_x[s] = b_x[s]; f_w[s] = b_w[s]; f_hf[s] = b_hf[s];
        end
        for (int s = 0; s < NS; s++) begin
            row = (ly - m_y[s]) & 1023;
            b_v[s]  = m_en[s] && (row < 16);
            b_x[s]  = m_x[s];
            b_hf[s] = m_hf[s];
            b_w[s]  = mem[m_id[s] * 16 + (row & 15)];
        end
        line_start = 1'b1; line_y = ly[YW-1:0];
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (fetch_busy === 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        n_vec++;
        if (fetch_busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: fetch_busy=%b required 0", fetch_busy);
        end
    endtask

    task automatic drive_pix(int px, bit pv);
        pix_x = px[XW-1:0]; pix_valid = pv;
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    function automatic void exp_pix(input int px, output bit hit, output int color, output int slot);
        int c, p, v;
        hit = 0; color = 0; slot = 0;
        for (int s = NS - 1; s >= 0; s--) begin
            c = (px - f_x[s]) & 1023;
            p = c;
`ifdef SPRITE_HFLIP_EN
            if (f_hf[s]) p = 15 - c;
`endif
            v = (c < 16) ? int'((f_w[s] >> (2 * p)) & 32'h3) : 0;
            if (f_v[s] && v != 0) begin
                hit = 1; color = v; slot = s;
            end
        end
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (fetch_busy !== 1'b0 || mem_raddr !== 9'h000 || pix_hit !== 1'b0 ||
            pix_color !== 2'd0 || pix_slot !== 3'd0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b raddr=%h hit=%b color=%0d slot=%0d required all 0",
                     fetch_busy, mem_raddr, pix_hit, pix_color, pix_slot);
        end
        reset = 1'b0;
        drive_pix(0, 1);
        n_vec++;
        if (pix_hit !== 1'b0 || fetch_busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: hit=%b busy=%b required 0/0", pix_hit, fetch_busy);
        end
    endtask

    task automatic test_fetch_basic();
        int cnt;
        mem[9'h035] = 32'h0000_000C;
        wr_attr(0, 1, 0, 3, 100, 50);
        start_line(105, NS);
        n_vec++;
        if (mem_raddr !== 9'h035 || fetch_busy !== 1'b1) begin
            n_err++;
            $display("FAIL first_issue: raddr=%h busy=%b required 035/1", mem_raddr, fetch_busy);
        end
        cnt = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fetch_busy !== 1'b1) break;
            cnt++;
        end
        n_vec++;
        if (cnt != 9) begin
            n_err++;
            $display("FAIL busy_length: %0d cycles required 9", cnt);
        end
    endtask

    task automatic test_display();
        start_line(106, NS);
        drive_pix(51, 1);
        n_vec++;
        if (pix_hit !== 1'b1 || pix_color !== 2'd3 || pix_slot !== 3'd0) begin
            n_err++;
            $display("FAIL display_x51: hit=%b color=%0d slot=%0d required 1/3/0", pix_hit, pix_color, pix_slot);
        end
        drive_pix(50, 1);
        n_vec++;
        if (pix_hit !== 1'b0 || pix_color !== 2'd0) begin
            n_err++;
            $display("FAIL display_transparent: hit=%b color=%0d required 0/0", pix_hit, pix_color);
        end
        drive_pix(66, 1);
        n_vec++;
        if (pix_hit !== 1'b0) begin
            n_err++;
            $display("FAIL display_out_of_range: hit=%b required 0", pix_hit);
        end
        drive_pix(51, 0);
        n_vec++;
        if (pix_hit !== 1'b0 || pix_color !== 2'd0) begin
            n_err++;
            $display("FAIL pix_valid_low: hit=%b color=%0d required 0/0", pix_hit, pix_color);
        end
        wait_idle();
    endtask

    task automatic test_priority();
        mem[9'h045] = 32'h0000_0400;   // pixel 5 colour 1
        mem[9'h065] = 32'h0020_0000;   // pixel 10 colour 2
        wr_attr(0, 0, 0, 3, 100, 50);
        wr_attr(2, 1, 0, 4, 100, 195);
        wr_attr(5, 1, 0, 6, 100, 190);
        start_line(105, NS);
        wait_idle();
        start_line(105, NS);
        drive_pix(200, 1);
        n_vec++;
        if (pix_hit !== 1'b1 || pix_color !== 2'd1 || pix_slot !== 3'd2) begin
            n_err++;
            $display("FAIL priority_low_slot: hit=%b color=%0d slot=%0d required 1/1/2", pix_hit, pix_color, pix_slot);
        end
        drive_pix(200, 0);
        n_vec++;
        if (pix_hit !== 1'b0 || pix_color !== 2'd0 || pix_slot !== 3'd2) begin
            n_err++;
            $display("FAIL slot_hold: hit=%b color=%0d slot=%0d required 0/0/2", pix_hit, pix_color, pix_slot);
        end
        wait_idle();
        mem[9'h045] = 32'h0000_0000;
        start_line(105, NS);
        wait_idle();
        start_line(105, NS);
        drive_pix(200, 1);
        n_vec++;
        if (pix_hit !== 1'b1 || pix_color !== 2'd2 || pix_slot !== 3'd5) begin
            n_err++;
            $display("FAIL priority_transparent: hit=%b color=%0d slot=%0d required 1/2/5", pix_hit, pix_color, pix_slot);
        end
        wait_idle();
    endtask

    task automatic test_row_miss();
        for (int r = 0; r < 16; r++) mem[7 * 16 + r] = 32'hFFFF_FFFF;
        mem[9'h077] = 32'h0000_0003;
        wr_attr(2, 0, 0, 4, 100, 195);
        wr_attr(5, 0, 0, 6, 100, 190);
        wr_attr(1, 1, 0, 7, 100, 300);
        start_line(116, NS);
        wait_idle();
        start_line(116, NS);
        for (int px = 296; px < 320; px++) begin
            drive_pix(px, 1);
            n_vec++;
            if (pix_hit !== 1'b0) begin
                n_err++;
                $display("FAIL row_miss x=%0d: hit=%b required 0", px, pix_hit);
            end
        end
        wait_idle();
        wr_attr(1, 1, 0, 7, 1020, 300);
        start_line(3, NS);
        @(negedge clk);                 // slot 1 is issued in the second fetch cycle
        n_vec++;
        if (mem_raddr !== 9'h077) begin
            n_err++;
            $display("FAIL row_wrap_addr: raddr=%h required 077", mem_raddr);
        end
        wait_idle();
        start_line(3, NS);
        drive_pix(300, 1);
        n_vec++;
        if (pix_hit !== 1'b1 || pix_color !== 2'd3 || pix_slot !== 3'd1) begin
            n_err++;
            $display("FAIL row_wrap_pix: hit=%b color=%0d slot=%0d required 1/3/1", pix_hit, pix_color, pix_slot);
        end
        wait_idle();
    endtask

    task automatic test_abort();
        for (int s = 0; s < 6; s++) begin
            for (int r = 0; r < 16; r++) mem[(8 + s) * 16 + r] = 32'hFFFF_FFFF;
            wr_attr(s, 1, 0, 8 + s, 200, s * 20);
        end
        wr_attr(6, 0, 0, 0, 0, 0);
        wr_attr(7, 0, 0, 0, 0, 0);
        start_line(203, NS);
        repeat (3) @(negedge clk);
        start_line(203, 3);
        n_vec++;
        if (fetch_busy !== 1'b1 || mem_raddr !== 9'h083) begin
            n_err++;
            $display("FAIL abort_restart: busy=%b raddr=%h required 1/083", fetch_busy, mem_raddr);
        end
        for (int s = 0; s < 6; s++) begin
            drive_pix(s * 20 + 5, 1);
            n_vec++;
            if (pix_hit !== (s < 3) || (s < 3 && (pix_color !== 2'd3 || pix_slot !== s[SW-1:0]))) begin
                n_err++;
                $display("FAIL abort_partial slot=%0d: hit=%b color=%0d slot=%0d required hit=%0d", s, pix_hit, pix_color, pix_slot, s < 3);
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        start_line(203, NS);
        repeat (2) @(negedge clk);
        reset = 1'b1; pix_valid = 1'b1; pix_x = 10'd5;
        @(negedge clk);
        n_vec++;
        if (fetch_busy !== 1'b0 || mem_raddr !== 9'h000 || pix_hit !== 1'b0 ||
            pix_color !== 2'd0 || pix_slot !== 3'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b raddr=%h hit=%b color=%0d slot=%0d required all 0",
                     fetch_busy, mem_raddr, pix_hit, pix_color, pix_slot);
        end
        reset = 1'b0; pix_valid = 1'b0;
        model_clear();
        for (int s = 0; s < 6; s++) wr_attr(s, 1, 0, 8 + s, 200, s * 20);
        start_line(203, NS);
        wait_idle();
        drive_pix(5, 1);
        n_vec++;
        if (pix_hit !== 1'b0) begin
            n_err++;
            $display("FAIL reset_one_fetch: hit=%b required 0", pix_hit);
        end
        start_line(203, NS);
        drive_pix(5, 1);
        n_vec++;
        if (pix_hit !== 1'b1 || pix_color !== 2'd3 || pix_slot !== 3'd0) begin
            n_err++;
            $display("FAIL reset_two_fetches: hit=%b color=%0d slot=%0d required 1/3/0", pix_hit, pix_color, pix_slot);
        end
        wait_idle();
    endtask

    task automatic test_hflip();
        bit e_hit400, e_hit415;
        for (int r = 0; r < 16; r++) mem[9 * 16 + r] = 32'h8000_0000;   // pixel 15 colour 2
        for (int s = 0; s < NS; s++) wr_attr(s, 0, 0, 0, 0, 0);
        wr_attr(0, 1, 1, 9, 300, 400);
`ifdef SPRITE_HFLIP_EN
        e_hit400 = 1; e_hit415 = 0;
`else
        e_hit400 = 0; e_hit415 = 1;
`endif
        start_line(305, NS);
        wait_idle();
        start_line(305, NS);
        drive_pix(400, 1);
        n_vec++;
        if (pix_hit !== e_hit400 || pix_color !== (e_hit400 ? 2'd2 : 2'd0)) begin
            n_err++;
            $display("FAIL hflip_x400: hit=%b color=%0d required hit=%b", pix_hit, pix_color, e_hit400);
        end
        drive_pix(415, 1);
        n_vec++;
        if (pix_hit !== e_hit415 || pix_color !== (e_hit415 ? 2'd2 : 2'd0)) begin
            n_err++;
            $display("FAIL hflip_x415: hit=%b color=%0d required hit=%b", pix_hit, pix_color, e_hit415);
        end
        wait_idle();
    endtask

    task automatic test_random();
        int base, ly, px, k, ec, es;
        bit eh, pv;
        for (int it = 0; it < 6; it++) begin
            base = $urandom_range(0, 1023);
            for (int s = 0; s < NS; s++)
                wr_attr(s, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                        $urandom_range(0, 31), base - $urandom_range(0, 20), $urandom_range(0, 1023));
            ly = base;
            start_line(ly, NS);
            wait_idle();
            start_line((ly + 1) & 1023, NS);
            for (int j = 0; j < 30; j++) begin
                k  = $urandom_range(0, NS - 1);
                px = (f_x[k] + $urandom_range(0, 17)) & 1023;
                pv = $urandom_range(0, 9) != 0;
                exp_pix(px, eh, ec, es);
                if (!pv) begin eh = 0; ec = 0; end
                drive_pix(px, pv);
                n_vec++;
                if (pix_hit !== eh || pix_color !== ec[1:0] || (eh && pix_slot !== es[SW-1:0])) begin
                    n_err++;
                    $display("FAIL random it=%0d x=%0d pv=%0b: hit=%b color=%0d slot=%0d required %b/%0d/%0d",
                             it, px, pv, pix_hit, pix_color, pix_slot, eh, ec, es);
                end
            end
            wait_idle();
        end
    endtask

    initial begin
        reset = 1'b1; attr_we = 1'b0; attr_slot = '0; attr_wdata = '0;
        line_start = 1'b0; line_y = '0; pix_valid = 1'b0; pix_x = '0;
        for (int a = 0; a < 512; a++) mem[a] = $urandom & $urandom;
        model_clear();
        test_reset();
        test_fetch_basic();
        test_display();
        test_priority();
        test_row_miss();
        test_abort();
        test_reset_mid();
        test_hflip();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
Read-side partner of the sprite memory: per scanline it scans NUM_SLOTS sprite attribute slots and fetches the matching 32-bit sprite line words through the memory's registered read port. It then serves per-pixel 2bpp colour to the video mixer. Fetch results are double-buffered, so the line being displayed is never disturbed by the next line's fetch.

Parameters:
NUM_SLOTS, 8, number of sprite attribute slots (power of 2, 2..16).
X_W, 10, pixel x coordinate width.
Y_W, 10, scanline y coordinate width.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
attr_we  in  1  write enable for the attribute slot.
attr_slot  in  $clog2(NUM_SLOTS)  attribute slot index.
attr_wdata  in  32  attribute word. [31] enable; [30] hflip; [29:25] reserved; [24:20] sprite id; [19:10] y; [9:0] x.
line_start  in  1  one-cycle pulse at the start of hblank.
line_y  in  Y_W  scanline to fetch; sampled on line_start.
mem_raddr  out  9  sprite memory read address {id, row[3:0]}.
mem_rdata  in  32  sprite memory read data, valid one cycle after mem_raddr.
fetch_busy  out  1  high while a fetch is in progress.
pix_valid  in  1  active-display pixel strobe.
pix_x  in  X_W  current pixel x.
pix_hit  out  1  a non-transparent sprite pixel is present.
pix_color  out  2  colour index of the winning sprite pixel.
pix_slot  out  $clog2(NUM_SLOTS)  slot that supplied the winning pixel.

Behaviour:
- Reset: all attribute enables cleared; both line-buffer banks invalid; FSM in IDLE; fetch_busy=0, mem_raddr=0, pix_hit=0, pix_color=0, pix_slot=0.
- Attribute writes take effect the next cycle. A write during FETCH applies to slots not yet issued.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE→FETCH on line_start. In the same cycle: swap banks, latch line_y, clear back-bank valid bits, set issue index to 0.
  - FETCH issues slot i at cycle i: mem_raddr={id_i, (line_y - y_i)[3:0]}.
  - Row hit for slot i: enable_i && (line_y - y_i) mod 2^Y_W < 16. The hit flag is piped alongside the address.
  - Capture for slot i-1 happens on the cycle after its issue: if its hit flag is set, store mem_rdata and the slot's x into the back bank and set its valid bit.
  - After slot NUM_SLOTS-1 is issued, go to DRAIN for one capture cycle, then IDLE.
  - Total fetch time is NUM_SLOTS+1 cycles. fetch_busy=1 in FETCH and DRAIN.
- line_start during FETCH or DRAIN: abort, swap banks (the partially fetched bank becomes front, only slots captured so far are valid), restart at slot 0. Pipeline hit flags are cleared on abort.
- Pixel path, 1-cycle latency. For each front-bank valid slot, col=(pix_x - x_s) mod 2^X_W; hit if col<16.
  - Pixel p of a line word is at bits [2p+1:2p].
  - Colour 0 is transparent.
  - The lowest-numbered hitting, non-transparent slot wins.
  - Registered next cycle: pix_hit, pix_color, pix_slot.
  - pix_valid=0 forces pix_hit=0 and pix_color=0 next cycle; pix_slot holds its value.
- Sprite bounds: a sprite at x near 2^X_W wraps onto the line start (modular compare). This is intended.

Optional Feature:
SPRITE_HFLIP_EN
- Defined: if attr bit30 is set, pixel index becomes 15-col, mirroring the sprite horizontally.
- Undefined: bit30 is ignored and not stored; pixel index is always col.

Decomposition:
- Package sprite_pkg holds:
  - SPR_W=16, SPR_H=16, BPP=2.
  - Attribute field bit positions (EN, HFLIP, ID, Y, X).
  - FSM state encoding.
- One sub-module, sprite_slot_line: per-slot double-buffered {valid, x, word} storage with bank select, column compare, and 2-bit pixel extract (hflip under macro). It is instantiated NUM_SLOTS times.
- The top level holds the attribute registers, FSM, and priority select.

Test Plan:
1. Attributes: slot0 {en, id=3, y=100, x=50}; line_start, line_y=105. Required: mem_raddr=0x035 in cycle 1; fetch_busy high 9 cycles.
2. Display: mem returns 0x0000000C for that word; next line_start swaps banks; drive pix_x=51. Required: pix_hit=1, pix_color=3, pix_slot=0 one cycle later. pix_x=50 gives pix_hit=0 (transparent). pix_x=66 gives pix_hit=0 (out of range).
3. Priority: slots 2 and 5 both cover pix_x=200 with colours 1 and 2. Required: pix_color=1, pix_slot=2. If slot 2's pixel is transparent: pix_color=2, pix_slot=5.
4. Row miss: slot y=100, line_y=116. Required: no capture; pix_hit=0 across the whole line. With y=1020 and line_y=3: row=7, hit, raddr row field=7.
5. Abort: second line_start 4 cycles into a fetch. Required: fetch restarts at slot 0; front bank shows only slots 0–2 valid; fetch_busy stays 1.
6. Reset mid-FETCH. Required: all outputs 0 next cycle, FSM IDLE, no pix_hit until attributes are rewritten and two fetches complete. SPRITE_HFLIP_EN with hflip set: pixel 15 appears at pix_x=x.
